// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write-back and operand read port bundle for register_file
interface register_file_if #(
  parameter int N_BITS = 32
);
  logic              Reg_Write_i;
  logic [4:0]        Write_Register_i;
  logic [N_BITS-1:0] Write_Data_i;
  logic [4:0]        Read_Register_1_i;
  logic [4:0]        Read_Register_2_i;
  logic [N_BITS-1:0] Read_Data_1_o;
  logic [N_BITS-1:0] Read_Data_2_o;

  modport master (
    output Reg_Write_i,
    output Write_Register_i,
    output Write_Data_i,
    output Read_Register_1_i,
    output Read_Register_2_i,
    input  Read_Data_1_o,
    input  Read_Data_2_o
  );

  modport slave (
    input  Reg_Write_i,
    input  Write_Register_i,
    input  Write_Data_i,
    input  Read_Register_1_i,
    input  Read_Register_2_i,
    output Read_Data_1_o,
    output Read_Data_2_o
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x N_BITS integer register file, 2 comb read ports, 1 write port; REGISTER_FILE_ABI_INIT_EN presets sp/gp
module register_file #(
  parameter int N_BITS = 32
`ifdef REGISTER_FILE_ABI_INIT_EN
  , parameter logic [N_BITS-1:0] SP_RESET = 32'h7FFF_EFFC
  , parameter logic [N_BITS-1:0] GP_RESET = 32'h1000_8000
`endif
) (
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  rf
);

  // x0 has no storage; only x1..x31 are flops
  logic [N_BITS-1:0] regs_q [1:31];
  logic [N_BITS-1:0] regs_d [1:31];

  // x0 is spliced in as a constant zero so both read ports index one full 32-entry view
  logic [N_BITS-1:0] read_view [0:31];

  // Build the read view: hardwired zero at index 0, live register contents elsewhere
  always_comb begin
    read_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      read_view[i] = regs_q[i];
    end
  end

  // Reads are straight muxes off the stored state: no write bypass, so the ALU
  // result path never loops back combinationally into its own operands
  assign rf.Read_Data_1_o = read_view[rf.Read_Register_1_i];
  assign rf.Read_Data_2_o = read_view[rf.Read_Register_2_i];

  // Next state: hold everything, load the addressed register when enabled;
  // the loop starts at 1, so a write aimed at x0 matches nothing and is dropped
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      if (rf.Reg_Write_i && (rf.Write_Register_i == 5'(i))) begin
        regs_d[i] = rf.Write_Data_i;
      end
    end
  end

  // Register array update; reset is asynchronous and overrides any pending write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
`ifdef REGISTER_FILE_ABI_INIT_EN
      regs_q[2] <= SP_RESET;
      regs_q[3] <= GP_RESET;
`endif
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard testbench for register_file
module tb_register_file;

  logic clk;
  logic reset;
  logic obs_valid;

  register_file_if #(.N_BITS(32)) rf_if ();

  register_file #(.N_BITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if.slave)
  );

`ifdef REGISTER_FILE_ABI_INIT_EN
  localparam logic [31:0] SP_EXP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_EXP = 32'h1000_8000;
`else
  localparam logic [31:0] SP_EXP = 32'h0;
  localparam logic [31:0] GP_EXP = 32'h0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] reset_val(input int i);
    return (i == 2) ? SP_EXP : ((i == 3) ? GP_EXP : 32'h0);
  endfunction

  function automatic logic [31:0] pat(input int i);
    return (i == 0) ? 32'h0 : (32'(i) * 32'h0101_0101);
  endfunction

  // Stimulus side: set read indices, queue the expectation, strobe the monitor
  task automatic check(input string tag, input int a, input int b,
                       input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    rf_if.Read_Register_1_i = 5'(a);
    rf_if.Read_Register_2_i = 5'(b);
    #1;
    e.tag = tag;
    e.e1  = ea;
    e.e2  = eb;
    sb.push_back(e);
    obs_valid = 1'b1;
    #1;
    obs_valid = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] data, input logic we);
    @(negedge clk);
    rf_if.Reg_Write_i      = we;
    rf_if.Write_Register_i = 5'(idx);
    rf_if.Write_Data_i     = data;
    @(negedge clk);
    rf_if.Reg_Write_i      = 1'b0;
  endtask

  // Monitor: pops one expectation per strobe and compares both read ports
  initial begin
    exp_t e;
    forever begin
      @(posedge obs_valid);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: strobe with empty scoreboard");
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (rf_if.Read_Data_1_o !== e.e1) begin
          n_bad++;
          $display("FAIL %s port1: got %h expected %h", e.tag, rf_if.Read_Data_1_o, e.e1);
        end
        n_cmp++;
        if (rf_if.Read_Data_2_o !== e.e2) begin
          n_bad++;
          $display("FAIL %s port2: got %h expected %h", e.tag, rf_if.Read_Data_2_o, e.e2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    obs_valid = 1'b0;
    reset = 1'b1;
    rf_if.Reg_Write_i       = 1'b0;
    rf_if.Write_Register_i  = 5'd0;
    rf_if.Write_Data_i      = 32'h0;
    rf_if.Read_Register_1_i = 5'd0;
    rf_if.Read_Register_2_i = 5'd0;

    // Reset values, asserted mid-cycle and read while held
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_x2_x3", 2, 3, SP_EXP, GP_EXP);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("rst_sweep", i, 31 - i, reset_val(i), reset_val(31 - i));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_released", 2, 3, SP_EXP, GP_EXP);

    // Basic write/read and neighbours
    wr(5, 32'hDEAD_BEEF, 1'b1);
    check("x5_both_ports", 5, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("x4_x6_untouched", 4, 6, 32'h0, 32'h0);

    // x0 protection and write disable
    wr(0, 32'hFFFF_FFFF, 1'b1);
    check("x0_write_dropped", 0, 0, 32'h0, 32'h0);
    wr(7, 32'h0000_0077, 1'b1);
    wr(7, 32'h0000_1234, 1'b0);
    check("x7_we_low_holds", 7, 0, 32'h0000_0077, 32'h0);

    // Read during write: old value before the edge, new value after
    wr(9, 32'h1, 1'b1);
    @(negedge clk);
    rf_if.Reg_Write_i      = 1'b1;
    rf_if.Write_Register_i = 5'd9;
    rf_if.Write_Data_i     = 32'h2;
    check("rdw_before_edge", 9, 9, 32'h1, 32'h1);
    @(posedge clk);
    #1;
    check("rdw_after_edge", 9, 9, 32'h2, 32'h2);
    @(negedge clk);
    rf_if.Reg_Write_i = 1'b0;

    // Async reset between edges while a write to x10 is pending
    wr(10, 32'hA5A5_A5A5, 1'b1);
    check("x10_preset", 10, 10, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    @(negedge clk);
    rf_if.Reg_Write_i      = 1'b1;
    rf_if.Write_Register_i = 5'd10;
    rf_if.Write_Data_i     = 32'h5;
    #3 reset = 1'b0;
    #1;
    check("async_rst_immediate", 10, 5, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge_no_write", 10, 10, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_before_edge", 10, 2, 32'h0, SP_EXP);
    @(posedge clk);
    #1;
    check("first_edge_writes", 10, 10, 32'h5, 32'h5);
    @(negedge clk);
    rf_if.Reg_Write_i = 1'b0;

    // Back-to-back writes on consecutive edges, then full sweep
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rf_if.Reg_Write_i      = 1'b1;
      rf_if.Write_Register_i = 5'(i);
      rf_if.Write_Data_i     = pat(i);
    end
    @(negedge clk);
    rf_if.Reg_Write_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("b2b_sweep", i, (i + 1) % 32, pat(i), pat((i + 1) % 32));
    end

    @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

32 x 32-bit integer register file for the single-cycle RISC-V core. It sits directly upstream of the ALU: its two read ports drive the ALU's A and B operand paths, and it receives the ALU result through the write-back path. Reads are combinational so the full instruction completes in one cycle. Writes commit on the rising clock edge.

## Interface
- N_BITS, 32, data width of every register and data port
- SP_RESET, 32'h7FFF_EFFC, reset value of x2 (sp); used only when the configuration macro is defined
- GP_RESET, 32'h1000_8000, reset value of x3 (gp); used only when the configuration macro is defined

- clk  input  1  system clock, rising-edge active; the only clock in the block
- reset  input  1  asynchronous, active-low reset
- Reg_Write_i  input  1  write enable for the current instruction
- Write_Register_i  input  5  destination register index (rd)
- Write_Data_i  input  N_BITS  write-back data (ALU result or load/jump data)
- Read_Register_1_i  input  5  source index rs1
- Read_Register_2_i  input  5  source index rs2
- Read_Data_1_o  output  N_BITS  contents of rs1, feeds ALU operand A
- Read_Data_2_o  output  N_BITS  contents of rs2, feeds ALU operand B mux / store data

## Operation
- Storage: registers x1..x31, each N_BITS wide. x0 has no storage.
- Read ports:
  - Purely combinational.
  - Read_Data_n_o equals the content of the indexed register.
  - An index of 0 always returns 0.
  - Both ports may address the same register and then return identical values.
- Write port:
  - On a rising edge of clk, with reset high, Reg_Write_i = 1 and Write_Register_i != 0, the indexed register loads Write_Data_i.
  - Every other register holds its value.
  - Reg_Write_i = 0 leaves all registers unchanged. Write_Register_i and Write_Data_i are don't-care in that case.
  - A write to x0 is discarded. x0 reads 0 forever.
- Read during write, same register in the same cycle:
  - Before the edge, the read port returns the old value. There is no bypass; a bypass would close a combinational loop through the ALU.
  - After the edge, the read port returns the new value.
- Width: all data is N_BITS. There is no sign handling inside the block.

## Timing
- Read latency: 0 cycles, combinational from the index inputs and register contents.
- Write latency: 1 edge. Data is visible on the read ports immediately after the committing edge.
- Reset:
  - reset = 0 immediately and asynchronously forces every register to its reset value, independent of clk.
  - Reset values: all registers 0, except x2/x3 as described under Configuration.
  - The read outputs therefore show reset values while reset is asserted.
- Reset mid-operation: an edge that coincides with reset = 0 performs no write. Reset wins over Reg_Write_i.
- Reset deassertion: the first rising edge with reset = 1 may write.
- There is no state machine. State is the register array only.

## Configuration
- Macro REGISTER_FILE_ABI_INIT_EN.
- Defined:
  - Reset loads x2 with SP_RESET and x3 with GP_RESET.
  - All other registers reset to 0.
- Undefined:
  - All registers reset to 0.
  - SP_RESET and GP_RESET are ignored.
  - Software must initialise sp and gp itself.

## Test plan
- Reset values: pulse reset low mid-cycle, then read x2 and x3.
  - With the macro: 32'h7FFF_EFFC and 32'h1000_8000.
  - Without the macro: 0 and 0.
  - All other indices read 0.
- Basic write/read: write x5 = 32'hDEAD_BEEF with Reg_Write_i = 1, then read rs1 = 5 and rs2 = 5.
  - Both ports return 32'hDEAD_BEEF after the edge.
  - x4 and x6 are unchanged.
- Write disabled and x0 protection:
  - Write x0 = 32'hFFFF_FFFF with Reg_Write_i = 1 -> x0 reads 0.
  - Write x7 = 32'h1234 with Reg_Write_i = 0 -> x7 keeps its previous value.
- Read during write: x9 = 32'h1, then drive a write of x9 = 32'h2 while reading rs1 = 9.
  - Before the edge: 32'h1.
  - After the edge: 32'h2.
- Async reset mid-operation: with x10 = 32'hA5A5_A5A5, assert reset low between edges while Reg_Write_i = 1 targets x10 with 32'h5.
  - x10 reads 0 immediately, before any clock edge.
  - The edge during reset does not write 32'h5.
- Back-to-back writes to all registers: write xi = i * 32'h0101_0101 for i = 1..31 on consecutive edges, then sweep reads on both ports.
  - Every register returns its pattern.
  - x0 returns 0.
